muldiv_unit: RTL and testbench

//   Iterative RV32M multiply/divide unit in the EX stage, beside the single-cycle ALU.
//   The ALU path returns results combinationally; this block accepts an M-extension op,

---
 rtl/muldiv_if.sv | 23 ++
 rtl/muldiv_unit.sv | 189 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
// The pipeline (master) issues an M-extension op and watches busy/done/result.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, rs1, rs2,
    input  busy, done, result
  );

  modport slave (
    input  start, op, rs1, rs2,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: magnitude shift-add / restoring divide over XLEN
// cycles, then a sign-fix cycle and a one-cycle done pulse. Latency is fixed per op.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic     i_clk,
  input  logic     i_reset,
  input  logic     i_flush,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic              r_neg_a;
  logic              r_neg_b;
  logic              r_dz;
  logic [XLEN-1:0]   r_a_orig;
  logic [XLEN-1:0]   r_b_abs;
  logic [2*XLEN-1:0] r_acc;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_sgn_a;
  logic              w_sgn_b;
  logic              w_neg_a;
  logic              w_neg_b;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_div_rem_sh;
  logic [XLEN:0]     w_div_diff;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_q_fix;
  logic [XLEN-1:0]   w_r_fix;
  logic [2*XLEN-1:0] w_fix;
  logic [XLEN-1:0]   w_sel;

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

  // Operand signedness and magnitudes; -0x80000000 stays 2^31 as an unsigned XLEN value.
  always_comb begin
    w_sgn_a = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
    w_sgn_b = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
    w_neg_a = w_sgn_a & bus.rs1[XLEN-1];
    w_neg_b = w_sgn_b & bus.rs2[XLEN-1];
    if (w_neg_a) begin
      w_abs_a = -bus.rs1;
    end else begin
      w_abs_a = bus.rs1;
    end
    if (w_neg_b) begin
      w_abs_b = -bus.rs2;
    end else begin
      w_abs_b = bus.rs2;
    end
  end

  // One iteration step; r_acc holds {high/remainder, low/quotient-in-progress}.
  always_comb begin
    if (r_acc[0]) begin
      w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_b_abs};
    end else begin
      w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]};
    end
    w_mul_next   = {w_mul_sum, r_acc[XLEN-1:1]};
    w_div_rem_sh = r_acc[2*XLEN-1:XLEN-1];
    w_div_diff   = w_div_rem_sh - {1'b0, r_b_abs};
    // The borrow bit alone tells whether the shifted remainder reached the divisor.
    if (!w_div_diff[XLEN]) begin
      w_div_next = {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    end else begin
      w_div_next = {w_div_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    end
  end

  // Sign correction with divide-by-zero override, then result-half selection.
  always_comb begin
    if (r_neg_a ^ r_neg_b) begin
      w_prod_fix = -r_acc;
      w_q_fix    = -r_acc[XLEN-1:0];
    end else begin
      w_prod_fix = r_acc;
      w_q_fix    = r_acc[XLEN-1:0];
    end
    if (r_neg_a) begin
      w_r_fix = -r_acc[2*XLEN-1:XLEN];
    end else begin
      w_r_fix = r_acc[2*XLEN-1:XLEN];
    end
    if (r_dz) begin
      w_q_fix = '1;
      w_r_fix = r_a_orig;
    end else begin
      w_q_fix = w_q_fix;
    end
    if (r_op[2]) begin
      w_fix = {w_r_fix, w_q_fix};
    end else begin
      w_fix = w_prod_fix;
    end
    case (r_op)
      3'd0, 3'd4, 3'd5: w_sel = r_acc[XLEN-1:0];
      3'd1, 3'd2, 3'd3,
      3'd6, 3'd7:       w_sel = r_acc[2*XLEN-1:XLEN];
      default:          w_sel = r_acc[XLEN-1:0];
    endcase
  end

  // Control FSM and datapath registers; reset clears everything, flush keeps result.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= 3'd0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_dz     <= 1'b0;
      r_a_orig <= '0;
      r_b_abs  <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else if (i_flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_op     <= bus.op;
            r_neg_a  <= w_neg_a;
            r_neg_b  <= w_neg_b;
            r_dz     <= (bus.rs2 == '0);
            r_a_orig <= bus.rs1;
            r_b_abs  <= w_abs_b;
            r_acc    <= {{XLEN{1'b0}}, w_abs_a};
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_CALC;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_acc <= r_op[2] ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(XLEN - 1)) begin
            r_state <= S_FIX;
          end else begin
            r_state <= S_CALC;
          end
        end
        S_FIX: begin
          r_acc   <= w_fix;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_result <= w_sel;
          r_done   <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: hand-computed RV32M results,
// fixed latency, busy length, ignored second start, and reset/flush aborts.
module tb_muldiv_unit;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  muldiv_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_flush (flush),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op; k counts negedges after the accepting edge (k=0 is the first cycle).
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit poke);
    int busy_n = 0;
    int done_n = 0;
    int done_k = -1;
    logic [31:0] res = 32'h0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.rs1   = a;
    bus.rs2   = b;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < XLEN + 10; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        done_k = k;
        res    = bus.result;
      end
      if (poke && k == 5) begin
        bus.start = 1'b1;
        bus.op    = 3'd0;
        bus.rs1   = 32'd3;
        bus.rs2   = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
    end
    check({tag, " result"}, res, exp);
    check({tag, " held"}, bus.result, exp);
    check({tag, " latency"}, 32'(done_k), 32'(XLEN + 2));
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(XLEN + 1));
    check({tag, " done_pulses"}, 32'(done_n), 32'd1);
  endtask

  // Start a MUL, abort it with reset or flush in CALC cycle 10, confirm no done.
  task automatic abort_op(input string tag, input bit use_reset, input logic [31:0] exp_res);
    int done_n = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd0;
    bus.rs1   = 32'd7;
    bus.rs2   = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    check({tag, " busy_mid"}, {31'd0, bus.busy}, 32'd1);
    if (use_reset) reset = 1'b1;
    else           flush = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    flush = 1'b0;
    check({tag, " busy_after"}, {31'd0, bus.busy}, 32'd0);
    check({tag, " result_after"}, bus.result, exp_res);
    for (int k = 0; k < XLEN + 10; k++) begin
      @(negedge clk);
      if (bus.done) done_n++;
    end
    check({tag, " no_done"}, 32'(done_n), 32'd0);
    check({tag, " result_final"}, bus.result, exp_res);
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.rs1   = 32'h0;
    bus.rs2   = 32'h0;
    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset result", bus.result, 32'h0);
    reset = 1'b0;

    run_op("MUL 7*-3",        3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run_op("MULH min*min",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    run_op("MULHU 2^31*2^31", 3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    run_op("MULHSU -1*max",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("MULHU max*max",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op("DIV -7/2",        3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0);
    run_op("REM -7/2",        3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0);
    run_op("DIVU big/2",      3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 1'b0);
    run_op("DIVU 5/0",        3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("REM -7/0",        3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1'b0);
    run_op("DIV ovf",         3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op("REM ovf",         3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    run_op("DIVU 100/7 poke", 3'd5, 32'd100,       32'd7,         32'd14,        1'b1);
    run_op("REMU 100/7",      3'd7, 32'd100,       32'd7,         32'd2,         1'b0);

    abort_op("flush", 1'b0, 32'd2);
    abort_op("reset", 1'b1, 32'h0);

    run_op("MUL after abort", 3'd0, 32'd6,         32'd7,         32'd42,        1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
